seg_display_scan: RTL and testbench



---
 rtl/seg_display_scan_pkg.sv | 33 +++
 rtl/seg_display_scan_hex_decode.sv | 14 +
 rtl/seg_display_scan.sv | 90 +++++++++
 tb/tb_seg_display_scan.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seg_display_scan_pkg.sv
// Shared definitions for the seven-segment scan driver: FSM states, off codes, hex font.
// Constants only; no latency or backpressure.
package seg_display_scan_pkg;

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low gfedcba font; entry 15 ('F') is listed first.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg_display_scan_hex_decode.sv
// Hex nibble to active-low seven-segment code.
// Purely combinational, zero latency; no flow control.
module seg_hex_decode
  import seg_display_scan_pkg::*;
(
  input  logic [3:0] m_nibble,
  output logic [6:0] m_seg_code
);

  always_comb begin
    m_seg_code = HEX_FONT[m_nibble];
  end

endmodule

// File: rtl/seg_display_scan.sv
// Four-digit common-anode scan driver with a dark gap before each digit; inputs snapshotted once per frame.
// Outputs registered, one cycle behind the scan state; free-running, no backpressure.
module seg_display_scan
  import seg_display_scan_pkg::*;
#(
  parameter int GAP_CYCLES = 1000,
  parameter int ON_CYCLES  = 99000
) (
  input  logic        m_clock,
  input  logic        m_reset,
  input  logic [15:0] m_value,
  input  logic [3:0]  m_blank,
  input  logic [3:0]  m_dp,
  output logic [3:0]  m_an,
  output logic [6:0]  m_seg,
  output logic        m_dp_n
);

  localparam int MAX_CYC = (GAP_CYCLES > ON_CYCLES) ? GAP_CYCLES : ON_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);

  scan_state_t      state;
  logic [1:0]       digit;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      snap_value;
  logic [3:0]       snap_blank;
  logic [3:0]       snap_dp;
  logic [3:0]       nibble;
  logic [6:0]       seg_code;

  always_comb begin
    nibble = snap_value[{digit, 2'b00} +: 4];
  end

  seg_hex_decode u_hex_decode (
    .m_nibble   (nibble),
    .m_seg_code (seg_code)
  );

  always_ff @(posedge m_clock) begin
    if (m_reset) begin
      state      <= ST_GAP;
      digit      <= 2'd0;
      cnt        <= '0;
      snap_value <= '0;
      snap_blank <= '0;
      snap_dp    <= '0;
      m_an       <= AN_OFF;
      m_seg      <= SEG_OFF;
      m_dp_n     <= 1'b1;
    end else begin
      // Start of frame: freeze inputs so a mid-frame change cannot tear across digits.
      if (state == ST_GAP && digit == 2'd0 && cnt == '0) begin
        snap_value <= m_value;
        snap_blank <= m_blank;
        snap_dp    <= m_dp;
      end

      if (state == ST_ON && !snap_blank[digit]) begin
        m_an   <= ~(4'b0001 << digit);
        m_seg  <= seg_code;
        m_dp_n <= ~snap_dp[digit];
      end else begin
        m_an   <= AN_OFF;
        m_seg  <= SEG_OFF;
        m_dp_n <= 1'b1;
      end

      if (state == ST_GAP) begin
        if (cnt == GAP_LAST) begin
          state <= ST_ON;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        if (cnt == ON_LAST) begin
          state <= ST_GAP;
          cnt   <= '0;
          digit <= digit + 2'd1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed table-driven bench for seg_display_scan with GAP_CYCLES=2, ON_CYCLES=4.
module tb_seg_display_scan;

  logic        m_clock = 1'b0;
  logic        m_reset;
  logic [15:0] m_value;
  logic [3:0]  m_blank;
  logic [3:0]  m_dp;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp_n;

  int n_checks = 0;
  int n_fail   = 0;

  seg_display_scan #(.GAP_CYCLES(2), .ON_CYCLES(4)) dut (
    .m_clock (m_clock),
    .m_reset (m_reset),
    .m_value (m_value),
    .m_blank (m_blank),
    .m_dp    (m_dp),
    .m_an    (m_an),
    .m_seg   (m_seg),
    .m_dp_n  (m_dp_n)
  );

  always #5 m_clock = ~m_clock;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  dp;
    int          digit;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
  } vec_t;

  vec_t vecs[21];

  task automatic tick();
    @(posedge m_clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] ean, input logic [6:0] eseg, input logic edp);
    n_checks++;
    if (m_an !== ean || m_seg !== eseg || m_dp_n !== edp) begin
      n_fail++;
      $display("FAIL %s: got an=%b seg=%b dp_n=%b, want an=%b seg=%b dp_n=%b",
               nm, m_an, m_seg, m_dp_n, ean, eseg, edp);
    end
  endtask

  task automatic chk_off(input string nm);
    chk(nm, 4'b1111, 7'b1111111, 1'b1);
  endtask

  // Two reset edges; the next edge is the first (snapshot) cycle of the frame.
  task automatic do_reset(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
    m_value = v;
    m_blank = b;
    m_dp    = d;
    m_reset = 1'b1;
    tick();
    tick();
    m_reset = 1'b0;
  endtask

  logic [6:0] frame1_seg [4];
  logic [3:0] an_of [4];

  initial begin
    m_reset = 1'b1;
    m_value = '0;
    m_blank = '0;
    m_dp    = '0;

    an_of = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    vecs[0]  = '{16'h1234, 4'b0000, 4'b0000, 0, 4'b1110, 7'b0011001, 1'b1};
    vecs[1]  = '{16'h1234, 4'b0000, 4'b0000, 1, 4'b1101, 7'b0110000, 1'b1};
    vecs[2]  = '{16'h1234, 4'b0000, 4'b0000, 2, 4'b1011, 7'b0100100, 1'b1};
    vecs[3]  = '{16'h1234, 4'b0000, 4'b0000, 3, 4'b0111, 7'b1111001, 1'b1};
    vecs[4]  = '{16'h7C5E, 4'b0000, 4'b0000, 0, 4'b1110, 7'b0000110, 1'b1};
    vecs[5]  = '{16'h7C5E, 4'b0000, 4'b0000, 1, 4'b1101, 7'b0010010, 1'b1};
    vecs[6]  = '{16'h7C5E, 4'b0000, 4'b0000, 2, 4'b1011, 7'b1000110, 1'b1};
    vecs[7]  = '{16'h7C5E, 4'b0000, 4'b0000, 3, 4'b0111, 7'b1111000, 1'b1};
    vecs[8]  = '{16'hFAB8, 4'b0000, 4'b0000, 0, 4'b1110, 7'b0000000, 1'b1};
    vecs[9]  = '{16'hFAB8, 4'b0000, 4'b0000, 1, 4'b1101, 7'b0000011, 1'b1};
    vecs[10] = '{16'hFAB8, 4'b0000, 4'b0000, 2, 4'b1011, 7'b0001000, 1'b1};
    vecs[11] = '{16'hFAB8, 4'b0000, 4'b0000, 3, 4'b0111, 7'b0001110, 1'b1};
    vecs[12] = '{16'h6D90, 4'b0000, 4'b0000, 0, 4'b1110, 7'b1000000, 1'b1};
    vecs[13] = '{16'h6D90, 4'b0000, 4'b0000, 1, 4'b1101, 7'b0010000, 1'b1};
    vecs[14] = '{16'h6D90, 4'b0000, 4'b0000, 2, 4'b1011, 7'b0100001, 1'b1};
    vecs[15] = '{16'h6D90, 4'b0000, 4'b0000, 3, 4'b0111, 7'b0000010, 1'b1};
    vecs[16] = '{16'h1234, 4'b0100, 4'b0000, 2, 4'b1111, 7'b1111111, 1'b1};
    vecs[17] = '{16'h1234, 4'b0100, 4'b0000, 3, 4'b0111, 7'b1111001, 1'b1};
    vecs[18] = '{16'h1234, 4'b0000, 4'b0010, 1, 4'b1101, 7'b0110000, 1'b0};
    vecs[19] = '{16'h1234, 4'b0000, 4'b0010, 0, 4'b1110, 7'b0011001, 1'b1};
    vecs[20] = '{16'h1234, 4'b1000, 4'b1000, 3, 4'b1111, 7'b1111111, 1'b1};

    // Reset held 3 cycles, then 2 dark cycles before digit 0 ('F') appears.
    m_value = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_off($sformatf("reset_hold%0d", i));
    end
    m_reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k >= 3 && k <= 6) chk($sformatf("reset_rel%0d", k), 4'b1110, 7'b0001110, 1'b1);
      else                  chk_off($sformatf("reset_rel%0d", k));
    end

    // One frame per vector; check the gap and ON cycles of the chosen digit's slot.
    for (int v = 0; v < 21; v++) begin
      do_reset(vecs[v].value, vecs[v].blank, vecs[v].dp);
      for (int k = 1; k <= 24; k++) begin
        tick();
        if ((k - 1) / 6 == vecs[v].digit) begin
          if ((k - 1) % 6 < 2) chk_off($sformatf("vec%0d_gap_k%0d", v, k));
          else chk($sformatf("vec%0d_on_k%0d", v, k), vecs[v].an, vecs[v].seg, vecs[v].dp_n);
        end
      end
    end

    // Value change while digit 1 is lit: frame 1 keeps 1234, frame 2 shows 8888.
    frame1_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    do_reset(16'h1234, 4'b0000, 4'b0000);
    for (int k = 1; k <= 48; k++) begin
      tick();
      if (((k - 1) % 24) % 6 < 2)
        chk_off($sformatf("tear_gap_k%0d", k));
      else if (k <= 24)
        chk($sformatf("tear_f1_k%0d", k), an_of[(k - 1) / 6], frame1_seg[(k - 1) / 6], 1'b1);
      else
        chk($sformatf("tear_f2_k%0d", k), an_of[(k - 25) / 6], 7'b0000000, 1'b1);
      if (k == 10) m_value = 16'h8888;
    end

    // Reset during digit 2 ON; restart shows 'A' on digit 0 after 2 dark cycles.
    do_reset(16'h1234, 4'b0000, 4'b0000);
    for (int k = 1; k <= 16; k++) tick();
    chk("midrst_pre", 4'b1011, 7'b0100100, 1'b1);
    m_value = 16'h000A;
    m_reset = 1'b1;
    tick();
    chk_off("midrst_assert");
    m_reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k >= 3 && k <= 6) chk($sformatf("midrst_k%0d", k), 4'b1110, 7'b0001000, 1'b1);
      else                  chk_off($sformatf("midrst_k%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
